// File: rtl/nv_blkbox_stream_src.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// nv_blkbox_stream_src
// Valid/ready stream source. It emits a bounded burst of deterministic
// pattern beats into a pipe input. It serves two purposes: tying off unused
// pipe inputs, and generating stimulus in the fabric during bring-up.
//
// Ports
//   nvdla_core_clk   : core clock; all logic runs on the rising edge
//   nvdla_core_rstn  : asynchronous active-low reset
//   cfg_start        : one-cycle start request; honoured only while idle
//   cfg_len          : number of beats in the burst (0 = immediate done)
//   cfg_mode         : 0 = incrementing counter, 1 = 32-bit Galois LFSR
//   cfg_seed         : initial 32-bit pattern state
//   src_pvld/src_prdy: output stream handshake
//   src_pd           : beat payload, low DW bits of the pattern state
//   busy             : high while the burst is being emitted
//   done             : one-cycle pulse when the burst completes
//   beat_cnt         : beats accepted in the current or last burst
// ---------------------------------------------------------------------------
module nv_blkbox_stream_src #(
   parameter int DW   = 32,
   parameter int LENW = 16
) (
   input  logic            nvdla_core_clk,
   input  logic            nvdla_core_rstn,
   input  logic            cfg_start,
   input  logic [LENW-1:0] cfg_len,
   input  logic            cfg_mode,
   input  logic [31:0]     cfg_seed,
   output logic            src_pvld,
   input  logic            src_prdy,
   output logic [DW-1:0]   src_pd,
   output logic            busy,
   output logic            done,
   output logic [LENW-1:0] beat_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Taps of x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   state_t          fsm_reg;
   logic [31:0]     pat_reg;
   logic            mode_reg;
   logic [LENW-1:0] rem_reg;
   logic [LENW-1:0] cnt_reg;
   logic            pvld_reg;
   logic            busy_reg;
   logic            done_reg;

   logic [31:0]     pat_next;
   logic [31:0]     seed_eff;
   logic            accept;

   always_comb begin
      pat_next = pat_reg + 32'd1;
      if (mode_reg) begin
         pat_next = pat_reg[0] ? ((pat_reg >> 1) ^ LFSR_TAPS) : (pat_reg >> 1);
      end
   end

   // The LFSR locks up at zero, so a zero seed is replaced in LFSR mode
   assign seed_eff = (cfg_mode && (cfg_seed == 32'd0)) ? 32'd1 : cfg_seed;

   // pvld_reg is only ever set in RUN, so this is an accept in RUN only
   assign accept = pvld_reg & src_prdy;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         fsm_reg  <= ST_IDLE;
         pat_reg  <= 32'd0;
         mode_reg <= 1'b0;
         rem_reg  <= '0;
         cnt_reg  <= '0;
         pvld_reg <= 1'b0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         case (fsm_reg)
            ST_IDLE: begin
               done_reg <= 1'b0;
               if (cfg_start) begin
                  pat_reg  <= seed_eff;
                  mode_reg <= cfg_mode;
                  rem_reg  <= cfg_len;
                  cnt_reg  <= '0;
                  if (cfg_len != '0) begin
                     fsm_reg  <= ST_RUN;
                     pvld_reg <= 1'b1;
                     busy_reg <= 1'b1;
                  end else begin
                     // An empty burst completes right away
                     fsm_reg  <= ST_FIN;
                     done_reg <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (accept) begin
                  pat_reg <= pat_next;
                  cnt_reg <= cnt_reg + LENW'(1);
                  rem_reg <= rem_reg - LENW'(1);
                  if (rem_reg == LENW'(1)) begin
                     fsm_reg  <= ST_FIN;
                     pvld_reg <= 1'b0;
                     busy_reg <= 1'b0;
                     done_reg <= 1'b1;
                  end
               end
            end
            ST_FIN: begin
               // Any start request during the done cycle is dropped
               done_reg <= 1'b0;
               fsm_reg  <= ST_IDLE;
            end
            default: begin
               fsm_reg  <= ST_IDLE;
               pvld_reg <= 1'b0;
               busy_reg <= 1'b0;
               done_reg <= 1'b0;
            end
         endcase
      end
   end

   assign src_pvld = pvld_reg;
   assign src_pd   = pat_reg[DW-1:0];
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign beat_cnt = cnt_reg;

endmodule
